// File: rtl/clk_en_ctrl.sv
// clk_en_ctrl: per-channel divided clock-enable generator with shadowed, terminal-count-aligned reconfiguration
module clk_en_ctrl #(
    parameter  int N_CH = 4,
    parameter  int CW   = 16,
    localparam int CHW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CHW-1:0]  cfg_ch,
    input  logic [CW-1:0]   cfg_div,
    input  logic            cfg_en,
    input  logic            sync,
    output logic [N_CH-1:0] tick,
    output logic [N_CH-1:0] div_out,
    output logic [N_CH-1:0] pending
);
    // A channel accepts a new request only once its previous one has been applied
    always_comb begin
        cfg_ready = 1'b0;
        for (int i = 0; i < N_CH; i++)
            if (cfg_ch == CHW'(i)) cfg_ready = ~pending[i];
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [CW-1:0] div_q, div_d, sdiv_q, sdiv_d, cnt_q, cnt_d, deff;
        logic en_q, en_d, sen_q, sen_d, pend_q, pend_d, tick_q, tick_d, dout_q, dout_d;
        logic tc, hs, apply;
        assign deff  = (div_q == '0) ? CW'(1) : div_q;
        assign tc    = en_q && (cnt_q == deff - CW'(1));
        assign hs    = cfg_valid && cfg_ready && (cfg_ch == CHW'(g));
        // Shadow moves to active on sync, at terminal count, or at once when the channel is idle
        assign apply = pend_q && (sync || tc || !en_q);
        // Next state: sync realigns everything, otherwise count toward terminal count
        always_comb begin
            div_d  = apply ? sdiv_q : div_q;
            en_d   = apply ? sen_q : en_q;
            sdiv_d = hs ? cfg_div : sdiv_q;
            sen_d  = hs ? cfg_en : sen_q;
            pend_d = hs || (pend_q && !apply);
            cnt_d  = (sync || tc || !en_q) ? '0 : cnt_q + CW'(1);
            tick_d = !sync && tc;
            dout_d = (sync || !en_d) ? 1'b0 : (tc ? ~dout_q : dout_q);
        end
        // Channel state registers; reset drops any in-flight update
        always_ff @(posedge clk) begin
            if (rst) begin
                div_q  <= CW'(1);
                en_q   <= 1'b0;
                cnt_q  <= '0;
                sdiv_q <= CW'(1);
                sen_q  <= 1'b0;
                pend_q <= 1'b0;
                tick_q <= 1'b0;
                dout_q <= 1'b0;
            end else begin
                div_q  <= div_d;
                en_q   <= en_d;
                cnt_q  <= cnt_d;
                sdiv_q <= sdiv_d;
                sen_q  <= sen_d;
                pend_q <= pend_d;
                tick_q <= tick_d;
                dout_q <= dout_d;
            end
        end
        assign tick[g]    = tick_q;
        assign div_out[g] = dout_q;
        assign pending[g] = pend_q;
    end
endmodule

// File: tb/tb_clk_en_ctrl.sv
// tb_clk_en_ctrl: scoreboard bench for the divided clock-enable controller
module tb_clk_en_ctrl;
    logic clk = 1'b0, rst = 1'b1, cfg_valid = 1'b0, cfg_en = 1'b0, sync = 1'b0;
    logic cfg_ready;
    logic [1:0] cfg_ch = '0;
    logic [15:0] cfg_div = '0;
    logic [3:0] tick, div_out, pending;
    int checks = 0, failures = 0;
    typedef struct {logic [3:0] t; logic [3:0] d; logic [3:0] p; int k;} exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    clk_en_ctrl #(.N_CH(4), .CW(16)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_en(cfg_en), .sync(sync),
        .tick(tick), .div_out(div_out), .pending(pending)
    );

    function automatic logic pt(int k, int d);
        return k >= d && k % d == 0;
    endfunction

    function automatic logic pd(int k, int d);
        return ((k / d) % 2) == 1;
    endfunction

    function automatic void push(logic [3:0] t, logic [3:0] d, logic [3:0] p, int k);
        sb.push_back('{t, d, p, k});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hs(int ch, int d, logic en);
        cfg_ch = 2'(ch);
        cfg_div = 16'(d);
        cfg_en = en;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        cfg_valid = 1'b0;
        sync = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        push(4'b0, 4'b0, 4'b0, 0);
        step();
        step();
        e = sb.pop_front();
        checks++;
        if ({tick, div_out, pending} !== {e.t, e.d, e.p}) begin
            failures++;
            $display("FAIL reset tick/div_out/pending=%b/%b/%b expected %b/%b/%b", tick, div_out, pending, e.t, e.d, e.p);
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cfg_ch = 2'(c);
            #1;
            checks++;
            if (cfg_ready !== 1'b1) begin
                failures++;
                $display("FAIL reset_ready ch=%0d cfg_ready=%b expected 1", c, cfg_ready);
            end
        end
    endtask

    task automatic test_basic();
        exp_t e;
        do_reset();
        cfg_ch = 2'd0;
        cfg_div = 16'd4;
        cfg_en = 1'b1;
        cfg_valid = 1'b1;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_ready_idle cfg_ready=%b expected 1", cfg_ready);
        end
        push(4'b0, 4'b0, 4'b0001, -1);
        step();
        cfg_valid = 1'b0;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_ready_pending cfg_ready=%b expected 0", cfg_ready);
        end
        for (int k = -1; k <= 16; k++) begin
            if (k >= 0) begin
                push({3'b0, pt(k, 4)}, {3'b0, pd(k, 4)}, 4'b0, k);
                step();
            end
            e = sb.pop_front();
            checks++;
            if ({tick, div_out, pending} !== {e.t, e.d, e.p}) begin
                failures++;
                $display("FAIL basic k=%0d tick/div_out/pending=%b/%b/%b expected %b/%b/%b", e.k, tick, div_out, pending, e.t, e.d, e.p);
            end
        end
    endtask

    task automatic test_div_change();
        exp_t e;
        do_reset();
        hs(0, 4, 1'b1);
        for (int k = 0; k <= 16; k++) begin
            if (k == 6) begin
                cfg_ch = 2'd0;
                cfg_div = 16'd2;
                cfg_en = 1'b1;
                cfg_valid = 1'b1;
            end
            if (k <= 8) push({3'b0, pt(k, 4)}, {3'b0, pd(k, 4)}, {3'b0, k == 6 || k == 7}, k);
            else push({3'b0, pt(k - 8, 2)}, {3'b0, pd(k - 8, 2)}, 4'b0, k);
            step();
            cfg_valid = 1'b0;
            e = sb.pop_front();
            checks++;
            if ({tick, div_out, pending} !== {e.t, e.d, e.p}) begin
                failures++;
                $display("FAIL div_change k=%0d tick/div_out/pending=%b/%b/%b expected %b/%b/%b", e.k, tick, div_out, pending, e.t, e.d, e.p);
            end
            if (k == 7 || k == 8) begin
                checks++;
                if (cfg_ready !== (k == 8)) begin
                    failures++;
                    $display("FAIL div_change_ready k=%0d cfg_ready=%b expected %b", k, cfg_ready, k == 8);
                end
            end
        end
    endtask

    task automatic test_sync();
        exp_t e;
        do_reset();
        hs(0, 3, 1'b1);
        step();
        hs(1, 3, 1'b1);
        step();
        step();
        sync = 1'b1;
        for (int m = 0; m <= 9; m++) begin
            push({2'b0, pt(m, 3), pt(m, 3)}, {2'b0, pd(m, 3), pd(m, 3)}, 4'b0, m);
            step();
            sync = 1'b0;
            e = sb.pop_front();
            checks++;
            if ({tick, div_out, pending} !== {e.t, e.d, e.p}) begin
                failures++;
                $display("FAIL sync m=%0d tick/div_out/pending=%b/%b/%b expected %b/%b/%b", e.k, tick, div_out, pending, e.t, e.d, e.p);
            end
        end
    endtask

    task automatic test_div01();
        exp_t e;
        do_reset();
        hs(0, 0, 1'b1);
        hs(1, 1, 1'b1);
        for (int j = 1; j <= 8; j++) begin
            push({2'b0, pt(j - 1, 1), pt(j, 1)}, {2'b0, pd(j - 1, 1), pd(j, 1)}, 4'b0, j);
            step();
            e = sb.pop_front();
            checks++;
            if ({tick, div_out, pending} !== {e.t, e.d, e.p}) begin
                failures++;
                $display("FAIL div01 j=%0d tick/div_out/pending=%b/%b/%b expected %b/%b/%b", e.k, tick, div_out, pending, e.t, e.d, e.p);
            end
        end
    endtask

    task automatic test_sync_hs();
        exp_t e;
        do_reset();
        hs(2, 5, 1'b1);
        repeat (8) step();
        sync = 1'b1;
        cfg_ch = 2'd2;
        cfg_div = 16'd7;
        cfg_en = 1'b1;
        cfg_valid = 1'b1;
        for (int m = 0; m <= 14; m++) begin
            push({1'b0, m == 5 || m == 12, 2'b0}, {1'b0, m >= 5 && m < 12, 2'b0}, {1'b0, m < 5, 2'b0}, m);
            step();
            sync = 1'b0;
            cfg_valid = 1'b0;
            e = sb.pop_front();
            checks++;
            if ({tick, div_out, pending} !== {e.t, e.d, e.p}) begin
                failures++;
                $display("FAIL sync_hs m=%0d tick/div_out/pending=%b/%b/%b expected %b/%b/%b", e.k, tick, div_out, pending, e.t, e.d, e.p);
            end
        end
    endtask

    task automatic test_reset_pending();
        exp_t e;
        do_reset();
        hs(0, 2, 1'b1);
        hs(1, 6, 1'b1);
        step();
        step();
        hs(1, 3, 1'b1);
        checks++;
        if (pending !== 4'b0010) begin
            failures++;
            $display("FAIL rst_pend_setup pending=%b expected 0010", pending);
        end
        rst = 1'b1;
        push(4'b0, 4'b0, 4'b0, 0);
        step();
        e = sb.pop_front();
        checks++;
        if ({tick, div_out, pending} !== {e.t, e.d, e.p}) begin
            failures++;
            $display("FAIL rst_pend tick/div_out/pending=%b/%b/%b expected %b/%b/%b", tick, div_out, pending, e.t, e.d, e.p);
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_pend_ready cfg_ready=%b expected 1", cfg_ready);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_change();
        test_sync();
        test_div01();
        test_sync_hs();
        test_reset_pending();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clk_en_ctrl.md
CLK_EN_CTRL -- requirements
Module: clk_en_ctrl

Interface
REQ-001 Parameter SHALL be N_CH, default 4, number of independent divided-enable channels (1..16).
REQ-002 Parameter SHALL be CW, default 16, divisor and counter width in bits.
REQ-003 Port clk SHALL be input, width 1, the single clock; every register in the block SHALL be clocked on its rising edge, with no derived or ripple clocks.
REQ-004 Port rst SHALL be input, width 1, reset, synchronous and active-high.
REQ-005 Port cfg_valid SHALL be input, width 1, configuration request.
REQ-006 Port cfg_ready SHALL be output, width 1, configuration accept.
REQ-007 Port cfg_ch SHALL be input, width max(1,$clog2(N_CH)), target channel index.
REQ-008 Port cfg_div SHALL be input, width CW, requested divisor D.
REQ-009 Port cfg_en SHALL be input, width 1, requested channel enable.
REQ-010 Port sync SHALL be input, width 1, single-cycle realign-all pulse.
REQ-011 Port tick SHALL be output, width N_CH, registered one-cycle enable pulse per channel.
REQ-012 Port div_out SHALL be output, width N_CH, registered 50%-duty divided level per channel.
REQ-013 Port pending SHALL be output, width N_CH, accepted configuration not yet applied, per channel.

Function
REQ-014 Each channel SHALL hold active registers (div, en, cnt) and shadow registers (sdiv, sen), plus a pending bit.
REQ-015 Effective divisor SHALL be max(div,1), so a divisor of 0 behaves as 1.
REQ-016 cfg_ready SHALL equal ~pending[cfg_ch] combinationally, and SHALL be 0 when cfg_ch >= N_CH.
REQ-017 A handshake SHALL occur on any edge with cfg_valid && cfg_ready; it SHALL load sdiv/sen of cfg_ch and set pending[cfg_ch].
REQ-018 Enabled channel counting: cnt SHALL increment each cycle and wrap to 0 after reaching Deff-1 (terminal count, TC).
REQ-019 On the edge where cnt==Deff-1, tick SHALL be set to 1 for one cycle and div_out SHALL toggle.
REQ-020 With Deff=1, tick SHALL remain high continuously and div_out SHALL toggle every cycle.
REQ-021 A pending update on an enabled channel SHALL be applied on its next TC edge: div<=sdiv, en<=sen, cnt<=0, pending cleared; the tick/toggle of that TC SHALL still occur.
REQ-022 A pending update on a disabled channel SHALL be applied on the edge after the handshake, giving one cycle of latency.
REQ-023 When a channel is enabled from disabled, cnt SHALL start at 0; the first tick SHALL occur on the Deff-th edge after the apply edge, and then every Deff edges.
REQ-024 Disabled channel: cnt SHALL be held at 0, tick=0, and div_out SHALL be forced to 0 on the apply edge.
REQ-025 On an edge where sync=1: every channel SHALL set cnt<=0, tick<=0 and div_out<=0; pending bits set before that cycle SHALL be applied on the same edge.
REQ-026 A handshake coinciding with sync SHALL be stored into the shadow and remain pending until the channel's next TC, or the next edge if the channel is disabled.
REQ-027 Phase alignment: channels with equal Deff SHALL emit coincident ticks after any sync.
REQ-028 Counter compare SHALL use CW-bit unsigned arithmetic, and a divisor of 2^CW-1 SHALL be supported without overflow.
REQ-029 A divisor change takes effect only at TC, so div_out SHALL never produce a high or low phase shorter than min(old Deff, new Deff) cycles.

Reset
REQ-030 While rst=1 on an edge: div<=1, en<=0, cnt<=0, sdiv<=1, sen<=0, pending<=0, tick<=0, div_out<=0.
REQ-031 The block SHALL give rst priority over sync and handshakes, and SHALL drop an in-flight pending update at reset.
REQ-032 After reset, cfg_ready SHALL be 1 for every valid cfg_ch.

Verification
REQ-033 Reset, then configure ch0 with D=4, en=1 -> applied 1 cycle after the handshake; tick[0] pulses every 4 cycles; div_out[0] has period 8 with duty 4/4.
REQ-034 Channel running D=4, then a handshake with D=2 mid-count -> pending=1 and cfg_ready=0 until TC; the old 4-cycle spacing completes, then ticks come every 2 cycles; no phase is shorter than 2 cycles.
REQ-035 ch0 D=3 and ch1 D=3 enabled at different times, then a sync pulse -> both tick together on the 3rd edge after sync; div_out both 0 immediately after sync.
REQ-036 Configure D=0 and D=1 on two channels -> tick held at 1 on both, div_out toggling every cycle.
REQ-037 Handshake and sync in the same cycle on an enabled ch2 (D=5 to D=7) -> pending[2] stays 1 through the sync edge; D=7 is applied at the first TC after sync (5 cycles later).
REQ-038 Assert rst while pending[1]=1 and channels are ticking -> next cycle all outputs are 0, pending=0, and cfg_ready=1.
